// File: rtl/npu_host_feeder.sv
// npu_host_feeder: streams a preloaded network image from a sync-read memory into one NPU,
// then collects its output vector. Define NPU_FEEDER_TIMEOUT_EN to enable the ready watchdog.
module npu_host_feeder #(
  parameter int          AW             = 12,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic          to_err,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic          npu_we,
  output logic          npu_oe,
  inout  wire  [31:0]   npu_data,
  input  logic          npu_ready,
  output logic          res_valid,
  output logic [4:0]    res_idx,
  output logic [31:0]   res_data
);

  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_CFG, S_WGT, S_INP, S_GAP, S_WAIT, S_READ
  } state_t;

  state_t     state;
  logic [1:0] num_layers;
  logic [4:0] n0, n1, n2, n3;
  logic [5:0] wcnt;
  logic [4:0] ncnt;
  logic [1:0] lidx;
  logic [4:0] fin, fout;
  logic       last_word, last_neuron, last_layer;

`ifdef NPU_FEEDER_TIMEOUT_EN
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT_CYCLES - 1);
  logic [11:0] tcnt;
`else
  assign to_err = 1'b0;
`endif

  // Image words go straight from memory onto the bus; the registered strobe qualifies them.
  assign npu_data = npu_we ? mem_rdata : 32'bz;

  // Fan-in/fan-out of the layer currently streaming; the last layer always fans out to n3.
  always_comb begin
    fin  = n0;
    fout = n3;
    case (lidx)
      2'd0: begin
        fin  = n0;
        fout = (num_layers == 2'd0) ? n3 : n1;
      end
      2'd1: begin
        fin  = n1;
        fout = (num_layers == 2'd1) ? n3 : n2;
      end
      default: begin
        fin  = n2;
        fout = n3;
      end
    endcase
  end

  assign last_word   = (wcnt == {1'b0, fin} + 6'd1);
  assign last_neuron = (ncnt == fout);
  assign last_layer  = (lidx == num_layers);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      npu_we     <= 1'b0;
      npu_oe     <= 1'b0;
      res_valid  <= 1'b0;
      res_idx    <= '0;
      res_data   <= '0;
      mem_addr   <= BASE;
      num_layers <= '0;
      n0         <= '0;
      n1         <= '0;
      n2         <= '0;
      n3         <= '0;
      wcnt       <= '0;
      ncnt       <= '0;
      lidx       <= '0;
`ifdef NPU_FEEDER_TIMEOUT_EN
      to_err     <= 1'b0;
      tcnt       <= '0;
`endif
    end else begin
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      res_valid <= 1'b0;
`ifdef NPU_FEEDER_TIMEOUT_EN
      to_err    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          // done is still high in the first idle cycle, so a start there is dropped
          if (start && !done) begin
            state    <= S_PRIME;
            busy     <= 1'b1;
            mem_addr <= BASE;
          end
        end
        S_PRIME: begin
          mem_addr <= mem_addr + 1'b1;
          npu_we   <= 1'b1;
          wcnt     <= '0;
          state    <= S_CFG;
        end
        S_CFG: begin
          mem_addr <= mem_addr + 1'b1;
          case (wcnt[2:0])
            3'd0:    num_layers <= mem_rdata[1:0];
            3'd1:    n0 <= mem_rdata[4:0];
            3'd2:    n1 <= mem_rdata[4:0];
            3'd3:    n2 <= mem_rdata[4:0];
            3'd4:    n3 <= mem_rdata[4:0];
            default: ;
          endcase
          if (wcnt == 6'd0 && mem_rdata[1:0] == 2'd3) begin
            cfg_err  <= 1'b1;
            npu_we   <= 1'b0;
            busy     <= 1'b0;
            mem_addr <= BASE;
            state    <= S_IDLE;
          end else if (wcnt == 6'd5) begin
            wcnt  <= '0;
            ncnt  <= '0;
            lidx  <= '0;
            state <= S_WGT;
          end else begin
            wcnt <= wcnt + 6'd1;
          end
        end
        S_WGT: begin
          mem_addr <= mem_addr + 1'b1;
          if (!last_word) begin
            wcnt <= wcnt + 6'd1;
          end else begin
            wcnt <= '0;
            if (!last_neuron) begin
              ncnt <= ncnt + 5'd1;
            end else begin
              ncnt <= '0;
              if (last_layer) state <= S_INP;
              else            lidx  <= lidx + 2'd1;
            end
          end
        end
        S_INP: begin
          if (wcnt == {1'b0, n0}) begin
            npu_we <= 1'b0;
            wcnt   <= '0;
            state  <= S_GAP;
          end else begin
            wcnt     <= wcnt + 6'd1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        S_GAP: begin
          mem_addr <= BASE;
          state    <= S_WAIT;
`ifdef NPU_FEEDER_TIMEOUT_EN
          tcnt     <= '0;
`endif
        end
        S_WAIT: begin
          if (npu_ready) begin
            npu_oe <= 1'b1;
            ncnt   <= '0;
            state  <= S_READ;
          end
`ifdef NPU_FEEDER_TIMEOUT_EN
          else if (tcnt == TO_LAST) begin
            to_err <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            tcnt <= tcnt + 12'd1;
          end
`endif
        end
        S_READ: begin
          res_valid <= 1'b1;
          res_idx   <= ncnt;
          res_data  <= npu_data;
          if (ncnt == n3) begin
            npu_oe <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            ncnt <= ncnt + 5'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_host_feeder.sv
// tb_npu_host_feeder: random network images through a memory/NPU model, scoreboarded against
// a layer-size reference model; the timeout case runs only when NPU_FEEDER_TIMEOUT_EN is defined.
module tb_npu_host_feeder;

  localparam int AW   = 12;
  localparam int BASE = 8;
  localparam int TO   = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, cfg_err, to_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          npu_we, npu_oe, npu_ready;
  wire  [31:0]   npu_data;
  logic          res_valid;
  logic [4:0]    res_idx;
  logic [31:0]   res_data;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } res_t;

  logic [31:0] img [0:(1<<AW)-1];
  logic [31:0] npu_words [0:31];
  logic [31:0] bus_q [$];
  res_t        res_q [$];
  int          oe_total = 0;
  int          npu_base = 0;
  int          img_len;
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 clk = ~clk;

  npu_host_feeder #(.AW(AW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cfg_err(cfg_err), .to_err(to_err), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .npu_we(npu_we), .npu_oe(npu_oe), .npu_data(npu_data), .npu_ready(npu_ready),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data)
  );

  always @(posedge clk) mem_rdata <= img[mem_addr];

  // NPU side: presents one prepared result word per oe cycle
  assign npu_data = npu_oe ? npu_words[5'(oe_total - npu_base)] : 32'bz;
  always @(posedge clk) if (npu_oe) oe_total <= oe_total + 1;

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pushWord(input logic [31:0] w);
    img[BASE + img_len] = w;
    bus_q.push_back(w);
    img_len++;
  endtask

  // Reference model: image = header, one block per consecutive layer-size pair, input vector.
  task automatic applyStimulus(input int l, input int n0, input int n1, input int n2,
                               input int n3, output int len);
    int          sizes[$];
    logic [31:0] w;
    res_t        r;
    sizes = {n0};
    if (l >= 1) sizes.push_back(n1);
    if (l >= 2) sizes.push_back(n2);
    sizes.push_back(n3);
    bus_q.delete();
    res_q.delete();
    img_len = 0;
    w = $urandom(); w[1:0] = 2'(l);  pushWord(w);
    w = $urandom(); w[4:0] = 5'(n0); pushWord(w);
    w = $urandom(); w[4:0] = 5'(n1); pushWord(w);
    w = $urandom(); w[4:0] = 5'(n2); pushWord(w);
    w = $urandom(); w[4:0] = 5'(n3); pushWord(w);
    pushWord($urandom());
    for (int i = 0; i + 1 < sizes.size(); i++)
      repeat ((sizes[i] + 2) * (sizes[i+1] + 1)) pushWord($urandom());
    repeat (n0 + 1) pushWord($urandom());
    img[BASE + img_len] = $urandom();
    len = img_len;
    npu_base = oe_total;
    for (int i = 0; i <= n3; i++) begin
      npu_words[i] = $urandom();
      r.idx  = 5'(i);
      r.data = npu_words[i];
      res_q.push_back(r);
    end
  endtask

  task automatic monitor();
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (npu_we) begin
          if (bus_q.size() == 0) checkOutput("bus_unexpected_we", 32'(npu_we), 32'd0);
          else                   checkOutput("bus_word", npu_data, bus_q.pop_front());
        end
        if (npu_we && npu_oe) checkOutput("bus_contention", 32'(npu_oe), 32'd0);
        if (res_valid) begin
          if (res_q.size() == 0) begin
            checkOutput("res_unexpected", 32'(res_valid), 32'd0);
          end else begin
            r = res_q.pop_front();
            checkOutput("res_idx", 32'(res_idx), 32'(r.idx));
            checkOutput("res_data", res_data, r.data);
            checkOutput("done_with_last", 32'(done), 32'(res_q.size() == 0));
          end
        end else if (done) begin
          checkOutput("done_without_res", 32'(done), 32'd0);
        end
      end
    end
  endtask

  task automatic pulseStart();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
    checkOutput("rst_to_err", 32'(to_err), 32'd0);
    checkOutput("rst_we", 32'(npu_we), 32'd0);
    checkOutput("rst_oe", 32'(npu_oe), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_idx", 32'(res_idx), 32'd0);
    checkOutput("rst_res_data", res_data, 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'(BASE));
    checkOutput("rst_bus_hiz", npu_data, 32'bz);
  endtask

  task automatic runInference(input int l, input int n0, input int n1, input int n2,
                              input int n3, input int ready_delay, input bit poke_start);
    int len, we_cycles, oe_cycles;
    applyStimulus(l, n0, n1, n2, n3, len);
    pulseStart();
    checkOutput("busy_prime", 32'(busy), 32'd1);
    checkOutput("we_prime", 32'(npu_we), 32'd0);
    @(negedge clk);
    checkOutput("we_first", 32'(npu_we), 32'd1);
    we_cycles = 0;
    for (int c = 0; c < 5000 && npu_we; c++) begin
      we_cycles++;
      @(negedge clk);
    end
    checkOutput("we_count", 32'(we_cycles), 32'(len));
    checkOutput("gap_hiz", npu_data, 32'bz);
    checkOutput("gap_busy", 32'(busy), 32'd1);
    for (int c = 0; c < ready_delay; c++) begin
      if (poke_start) start = (c == 1);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("oe_before_ready", 32'(npu_oe), 32'd0);
    checkOutput("to_err_quiet", 32'(to_err), 32'd0);
    npu_ready = 1'b1;
    for (int c = 0; c < 50 && !npu_oe; c++) @(negedge clk);
    checkOutput("oe_rise", 32'(npu_oe), 32'd1);
    oe_cycles = 0;
    for (int c = 0; c < 64 && npu_oe; c++) begin
      oe_cycles++;
      @(negedge clk);
    end
    npu_ready = 1'b0;
    checkOutput("oe_count", 32'(oe_cycles), 32'(n3 + 1));
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_fall", 32'(busy), 32'd0);
    if (poke_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_once", 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("no_rerun", 32'(busy), 32'd0);
    #1;
    checkOutput("bus_q_drained", 32'(bus_q.size()), 32'd0);
    checkOutput("res_q_drained", 32'(res_q.size()), 32'd0);
  endtask

  task automatic cfgErrTest();
    logic [31:0] w0;
    bus_q.delete();
    res_q.delete();
    w0 = $urandom();
    w0[1:0] = 2'd3;
    img[BASE] = w0;
    bus_q.push_back(w0);
    for (int i = 1; i < 8; i++) img[BASE + i] = $urandom();
    pulseStart();
    @(negedge clk);
    checkOutput("cfg_we_w0", 32'(npu_we), 32'd1);
    checkOutput("cfg_err_early", 32'(cfg_err), 32'd0);
    @(negedge clk);
    checkOutput("cfg_err_pulse", 32'(cfg_err), 32'd1);
    checkOutput("cfg_we_drop", 32'(npu_we), 32'd0);
    checkOutput("cfg_busy_drop", 32'(busy), 32'd0);
    checkOutput("cfg_bus_hiz", npu_data, 32'bz);
    checkOutput("cfg_no_done", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("cfg_err_single", 32'(cfg_err), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("cfg_stays_idle", 32'(busy), 32'd0);
    #1;
    checkOutput("cfg_bus_q_drained", 32'(bus_q.size()), 32'd0);
  endtask

  task automatic resetMidWgtTest();
    int len;
    applyStimulus(1, 2, 3, 0, 1, len);
    pulseStart();
    repeat (11) @(negedge clk);
    checkOutput("mid_wgt_we", 32'(npu_we), 32'd1);
    rst = 1'b1;
    #1;
    checkResetState();
    @(negedge clk);
    rst = 1'b0;
    bus_q.delete();
    res_q.delete();
    @(negedge clk);
    checkOutput("post_reset_idle", 32'(busy), 32'd0);
  endtask

`ifdef NPU_FEEDER_TIMEOUT_EN
  task automatic timeoutTest();
    int len, cnt;
    bit oe_seen;
    applyStimulus(0, 1, 0, 0, 0, len);
    npu_ready = 1'b0;
    pulseStart();
    @(negedge clk);
    for (int c = 0; c < 5000 && npu_we; c++) @(negedge clk);
    cnt = 0;
    oe_seen = 1'b0;
    for (int c = 0; c < 200 && !to_err; c++) begin
      @(negedge clk);
      cnt++;
      if (npu_oe) oe_seen = 1'b1;
    end
    checkOutput("to_err_pulse", 32'(to_err), 32'd1);
    checkOutput("to_latency", 32'(cnt), 32'(TO + 1));
    checkOutput("to_busy", 32'(busy), 32'd0);
    checkOutput("to_no_done", 32'(done), 32'd0);
    checkOutput("to_no_oe", 32'(oe_seen), 32'd0);
    @(negedge clk);
    checkOutput("to_err_single", 32'(to_err), 32'd0);
    res_q.delete();
    checkOutput("to_bus_q_drained", 32'(bus_q.size()), 32'd0);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    npu_ready = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    checkResetState();
    rst = 1'b0;
    @(negedge clk);

    runInference(0, 1, 0, 0, 0, 3, 1'b0);
    runInference(2, 3, 7, 1, 2, 5, 1'b0);
    for (int k = 0; k < 5; k++)
      runInference($urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(2, 12), 1'b0);
    runInference(1, 31, 0, 0, 31, 2, 1'b0);
    runInference(0, 0, 0, 0, 0, 2, 1'b0);
    cfgErrTest();
    runInference(1, 4, 2, 0, 3, 4, 1'b0);
    resetMidWgtTest();
    runInference(1, 2, 3, 0, 1, 4, 1'b0);
    runInference(0, 2, 0, 0, 3, 6, 1'b1);
`ifdef NPU_FEEDER_TIMEOUT_EN
    timeoutTest();
    runInference(2, 1, 2, 3, 1, 3, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
